ram_pattern_tester: RTL and testbench

Parametrised memory pattern generator/checker for one MIG user port, replacing host-driven pipe write/readback as the self-test engine behind the RAMTester design. After calibration, a start pulse makes the block write `NUM_BURSTS` bursts of a selectable pattern from a base address, read them back, and compare word by word. It reports an error count, the first failing address and a pass counter. Loop mode repeats the run with a new seed until stopped.

---
 rtl/ram_pattern_tester.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ram_pattern_tester.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_pattern_tester.sv
// ram_pattern_tester: memory self-test engine for one MIG user port.
// After calibration a start pulse writes num_bursts bursts of a generated
// pattern from base_addr, reads them back and compares word by word.
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   calib_done, start, stop       run control (start sampled in IDLE only)
//   mode, loop_en, seed           pattern select, repeat enable, pattern seed
//   base_addr, num_bursts         run geometry (0 bursts treated as 1)
//   cmd_*                         MIG command port (cmd_full back-pressure)
//   wr_*                          MIG write data port (wr_full back-pressure)
//   rd_*                          MIG read data port (rd_empty flow control)
//   busy, done, aborted           run status
//   error_count, first_err_addr   saturating mismatch count, first bad address
//   pass_count                    completed runs since the last start
module ram_pattern_tester #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    calib_done,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic                    loop_en,
    input  logic [31:0]             seed,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    num_bursts,
    output logic                    cmd_en,
    output logic [2:0]              cmd_instr,
    output logic [5:0]              cmd_bl,
    output logic [ADDR_WIDTH-1:0]   cmd_byte_addr,
    input  logic                    cmd_full,
    output logic                    wr_en,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    wr_full,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_empty,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_WIDTH-1:0]    error_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic [CNT_WIDTH-1:0]    pass_count
);

    localparam int unsigned LANES      = DATA_WIDTH / 32;
    localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
    localparam int unsigned WCNT_W     = 7;
    localparam logic [WCNT_W-1:0]     LAST_WORD  = WCNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_LEN * WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(WORD_BYTES);
    // x^32 + x^22 + x^2 + x + 1, left-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_FILL = 3'd1,
        WR_CMD  = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4,
        NEXT    = 3'd5
    } state_t;

    state_t                state;
    logic [1:0]            mode_r;
    logic [31:0]           seed_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CNT_WIDTH-1:0]  nb_r;
    logic [31:0]           gen_r;
    logic [WCNT_W-1:0]     wcnt;
    logic [CNT_WIDTH-1:0]  burst_idx;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  err_seen;
    logic [DATA_WIDTH-1:0] gen_word;
    logic                  cmd_state;
    logic                  run_start;
    logic                  last_burst;

    // Generator state right after a reload; walking-one uses gen_r[4:0] as its index
    function automatic logic [31:0] gen_load(input logic [1:0] m, input logic [31:0] s);
        case (m)
            2'd1:    gen_load = (s == 32'd0) ? 32'd1 : s;
            2'd2:    gen_load = 32'd0;
            default: gen_load = s;
        endcase
    endfunction

    function automatic logic [31:0] gen_step(input logic [1:0] m, input logic [31:0] g);
        case (m)
            2'd0, 2'd2: gen_step = g + 32'd1;
            2'd1:       gen_step = {g[30:0], 1'b0} ^ (g[31] ? LFSR_POLY : 32'd0);
            default:    gen_step = g;
        endcase
    endfunction

    // Current pattern word, 32-bit lanes across the data bus
    always_comb begin
        gen_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_r == 2'd2) begin
                gen_word[i*32 +: 32] = 32'd1 << 5'(gen_r[4:0] + 5'(i));
            end else begin
                gen_word[i*32 +: 32] = gen_r;
            end
        end
    end

    // Handshake strobes follow flow control combinationally so none fires while blocked
    assign cmd_state     = (state == WR_CMD) || (state == RD_CMD);
    assign cmd_en        = cmd_state && !cmd_full;
    assign wr_en         = (state == WR_FILL) && !wr_full;
    assign rd_en         = (state == RD_DATA) && !rd_empty;
    assign cmd_instr     = (state == RD_CMD) ? 3'b001 : 3'b000;
    assign cmd_bl        = cmd_state ? 6'(BURST_LEN - 1) : 6'd0;
    assign cmd_byte_addr = cmd_state ? addr_r : '0;
    assign wr_data       = (state == WR_FILL) ? gen_word : '0;
    assign wr_mask       = '0;

    assign run_start  = (state == IDLE) && start && calib_done;
    assign last_burst = (burst_idx == nb_r - CNT_WIDTH'(1));

    // Run sequencer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            pass_count <= '0;
            mode_r     <= 2'd0;
            seed_r     <= 32'd0;
            base_r     <= '0;
            nb_r       <= '0;
            gen_r      <= 32'd0;
            wcnt       <= '0;
            burst_idx  <= '0;
            addr_r     <= '0;
            rd_addr    <= '0;
        end else if (stop && (state != IDLE)) begin
            // A handshake on this edge still completes; nothing new is issued
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        mode_r     <= mode;
                        seed_r     <= seed;
                        base_r     <= base_addr;
                        nb_r       <= (num_bursts == '0) ? CNT_WIDTH'(1) : num_bursts;
                        gen_r      <= gen_load(mode, seed);
                        wcnt       <= '0;
                        burst_idx  <= '0;
                        addr_r     <= base_addr;
                        done       <= 1'b0;
                        aborted    <= 1'b0;
                        pass_count <= '0;
                        busy       <= 1'b1;
                        state      <= WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (wr_en) begin
                        gen_r <= gen_step(mode_r, gen_r);
                        if (wcnt == LAST_WORD) begin
                            wcnt  <= '0;
                            state <= WR_CMD;
                        end else begin
                            wcnt <= wcnt + WCNT_W'(1);
                        end
                    end
                end
                WR_CMD: begin
                    if (cmd_en) begin
                        if (last_burst) begin
                            burst_idx <= '0;
                            addr_r    <= base_r;
                            gen_r     <= gen_load(mode_r, seed_r);
                            state     <= RD_CMD;
                        end else begin
                            burst_idx <= burst_idx + CNT_WIDTH'(1);
                            addr_r    <= addr_r + BURST_STEP;
                            state     <= WR_FILL;
                        end
                    end
                end
                RD_CMD: begin
                    if (cmd_en) begin
                        rd_addr <= addr_r;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_en) begin
                        gen_r   <= gen_step(mode_r, gen_r);
                        rd_addr <= rd_addr + WORD_STEP;
                        if (wcnt == LAST_WORD) begin
                            wcnt <= '0;
                            if (last_burst) begin
                                state <= NEXT;
                            end else begin
                                burst_idx <= burst_idx + CNT_WIDTH'(1);
                                addr_r    <= addr_r + BURST_STEP;
                                state     <= RD_CMD;
                            end
                        end else begin
                            wcnt <= wcnt + WCNT_W'(1);
                        end
                    end
                end
                NEXT: begin
                    pass_count <= pass_count + CNT_WIDTH'(1);
                    if (loop_en) begin
                        seed_r    <= seed_r + 32'd1;
                        gen_r     <= gen_load(mode_r, seed_r + 32'd1);
                        burst_idx <= '0;
                        addr_r    <= base_r;
                        state     <= WR_FILL;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-back checker: saturating error count and first failing address
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            error_count    <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
        end else if (run_start) begin
            error_count <= '0;
            err_seen    <= 1'b0;
        end else if (rd_en && (rd_data != gen_word)) begin
            if (error_count != '1) begin
                error_count <= error_count + CNT_WIDTH'(1);
            end
            if (!err_seen) begin
                err_seen       <= 1'b1;
                first_err_addr <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_ram_pattern_tester.sv
// tb_ram_pattern_tester: directed bench with a reactive MIG port model and
// scoreboards for write data and command stream.
module tb_ram_pattern_tester;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 30;
    localparam int unsigned BL = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          calib_done;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic          loop_en;
    logic [31:0]   seed;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_bursts;
    logic          cmd_en;
    logic [2:0]    cmd_instr;
    logic [5:0]    cmd_bl;
    logic [AW-1:0] cmd_byte_addr;
    logic          cmd_full;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] wr_mask;
    logic          wr_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_empty;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] error_count;
    logic [AW-1:0] first_err_addr;
    logic [CW-1:0] pass_count;

    ram_pattern_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .calib_done(calib_done),
        .start(start), .stop(stop), .mode(mode), .loop_en(loop_en),
        .seed(seed), .base_addr(base_addr), .num_bursts(num_bursts),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .busy(busy), .done(done), .aborted(aborted),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .pass_count(pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboards filled when a run is launched, drained as the DUT emits
    logic [31:0] exp_wr[$];
    logic [32:0] exp_cmd[$];

    // Memory model state
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] mem [logic [AW-1:0]];
    int  n_wcmd;
    int  n_rcmd;
    int  rd_pops;
    bit  stall_en;
    bit  fault_en;
    bit  corrupt_all;
    logic pop_pend;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: word w after a reload
    function automatic logic [31:0] pat_word(input logic [1:0] m, input logic [31:0] s, input int w);
        logic [31:0] x;
        case (m)
            2'd0: x = s + 32'(w);
            2'd1: begin
                x = (s == 32'd0) ? 32'd1 : s;
                for (int k = 0; k < w; k++) x = {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0);
            end
            2'd2: x = 32'd1 << (w % 32);
            default: x = s;
        endcase
        return x;
    endfunction

    task automatic push_run(input logic [1:0] m, input logic [31:0] s, input logic [AW-1:0] base,
                            input int nb, input int passes);
        int nbe;
        logic [AW-1:0] a;
        nbe = (nb == 0) ? 1 : nb;
        for (int p = 0; p < passes; p++) begin
            for (int b = 0; b < nbe; b++) begin
                for (int k = 0; k < BL; k++) exp_wr.push_back(pat_word(m, s + 32'(p), b * BL + k));
                a = base + AW'(b * BL * 4);
                exp_cmd.push_back({3'b000, a});
            end
            for (int b = 0; b < nbe; b++) begin
                a = base + AW'(b * BL * 4);
                exp_cmd.push_back({3'b001, a});
            end
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] s, input logic [AW-1:0] base,
                             input logic [CW-1:0] nb, input logic lp);
        @(posedge clk); #1;
        mode = m; seed = s; base_addr = base; num_bursts = nb; loop_en = lp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 64'(busy), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd_en"}, 64'(cmd_en), 64'd0);
        chk({tag, "_cmd_instr"}, 64'(cmd_instr), 64'd0);
        chk({tag, "_cmd_bl"}, 64'(cmd_bl), 64'd0);
        chk({tag, "_cmd_addr"}, 64'(cmd_byte_addr), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_wr_mask"}, 64'(wr_mask), 64'd0);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_aborted"}, 64'(aborted), 64'd0);
        chk({tag, "_error_count"}, 64'(error_count), 64'd0);
        chk({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
        chk({tag, "_pass_count"}, 64'(pass_count), 64'd0);
    endtask

    task automatic check_end(input string tag, input int errs, input int passes);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_aborted"}, 64'(aborted), 64'd0);
        chk({tag, "_error_count"}, 64'(error_count), 64'(errs));
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(passes));
        chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        chk({tag, "_cmd_left"}, 64'(exp_cmd.size()), 64'd0);
    endtask

    // Reactive MIG model: handshakes seen at negedge complete on the next posedge
    initial begin
        wr_full = 1'b0; cmd_full = 1'b0; rd_empty = 1'b1; rd_data = '0;
        forever begin
            @(negedge clk);
            pop_pend = 1'b0;
            if (rst_n === 1'b1) begin
                if (wr_full) chk("wr_en_while_full", 64'(wr_en), 64'd0);
                if (cmd_full) chk("cmd_en_while_full", 64'(cmd_en), 64'd0);
                if (wr_en) begin
                    wq.push_back(wr_data);
                    chk("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
                    if (exp_wr.size() > 0) chk("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
                end
                if (cmd_en) begin
                    chk("cmd_expected", 64'(exp_cmd.size() > 0), 64'd1);
                    if (exp_cmd.size() > 0) chk("cmd_instr_addr", 64'({cmd_instr, cmd_byte_addr}), 64'(exp_cmd.pop_front()));
                    chk("cmd_bl", 64'(cmd_bl), 64'(BL - 1));
                    for (int k = 0; k < BL; k++) begin
                        m_addr = cmd_byte_addr + AW'(4 * k);
                        if (cmd_instr == 3'b000) begin
                            mem[m_addr] = (wq.size() > 0) ? wq.pop_front() : 32'h0;
                        end else begin
                            m_data = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
                            if (fault_en && m_addr == AW'(32'h94)) m_data[5] = ~m_data[5];
                            if (corrupt_all) m_data = ~m_data;
                            rq.push_back(m_data);
                        end
                    end
                    if (cmd_instr == 3'b000) n_wcmd++;
                    else n_rcmd++;
                end
                if (rd_en) pop_pend = 1'b1;
            end
            @(posedge clk); #1;
            if (pop_pend && rq.size() > 0) begin
                void'(rq.pop_front());
                rd_pops++;
            end
            wr_full  = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_empty = (rq.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
            rd_data  = (rq.size() > 0) ? rq[0] : '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        rst_n = 1'b0; calib_done = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        loop_en = 1'b0; seed = 32'd0; base_addr = '0; num_bursts = '0;
        stall_en = 0; fault_en = 0; corrupt_all = 0;
        n_wcmd = 0; n_rcmd = 0; rd_pops = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // start ignored before calibration
        start_run(2'd0, 32'h10, '0, CW'(1), 1'b0);
        repeat (4) @(negedge clk);
        chk("gate_busy", 64'(busy), 64'd0);
        chk("gate_wr_en", 64'(wr_en), 64'd0);
        chk("gate_cmd_en", 64'(cmd_en), 64'd0);
        calib_done = 1'b1;

        // clean increment run
        n_wcmd = 0; n_rcmd = 0;
        push_run(2'd0, 32'h10, '0, 4, 1);
        start_run(2'd0, 32'h10, '0, CW'(4), 1'b0);
        wait_done(3000, "clean");
        check_end("clean", 0, 1);
        chk("clean_wr_cmds", 64'(n_wcmd), 64'd4);
        chk("clean_rd_cmds", 64'(n_rcmd), 64'd4);

        // LFSR with bit 5 of word 37 flipped on read-back
        fault_en = 1;
        push_run(2'd1, 32'h0000_ACE1, '0, 2, 1);
        start_run(2'd1, 32'h0000_ACE1, '0, CW'(2), 1'b0);
        wait_done(3000, "fault");
        fault_en = 0;
        check_end("fault", 1, 1);
        chk("fault_first_err_addr", 64'(first_err_addr), 64'h94);

        // async reset in the middle of a write fill
        push_run(2'd0, 32'h77, '0, 2, 1);
        start_run(2'd0, 32'h77, '0, CW'(2), 1'b0);
        n = 0;
        while (exp_wr.size() > 58 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_in_fill", 64'(wr_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk); #2;
        exp_wr.delete(); exp_cmd.delete(); wq.delete(); rq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // random back-pressure on every flow-control input
        stall_en = 1;
        push_run(2'd1, 32'h1234, AW'(32'h1000), 3, 1);
        start_run(2'd1, 32'h1234, AW'(32'h1000), CW'(3), 1'b0);
        wait_done(8000, "bp");
        stall_en = 0;
        check_end("bp", 0, 1);

        // walking one, num_bursts 0 behaves as one burst
        n_wcmd = 0; n_rcmd = 0;
        push_run(2'd2, 32'h0, AW'(32'h400), 0, 1);
        start_run(2'd2, 32'h0, AW'(32'h400), CW'(0), 1'b0);
        wait_done(2000, "walk");
        check_end("walk", 0, 1);
        chk("walk_wr_cmds", 64'(n_wcmd), 64'd1);
        chk("walk_rd_cmds", 64'(n_rcmd), 64'd1);

        // address wrap at the top of the byte address space
        push_run(2'd0, 32'hFFFF_FFF0, AW'(32'h3FFF_FF80), 2, 1);
        start_run(2'd0, 32'hFFFF_FFF0, AW'(32'h3FFF_FF80), CW'(2), 1'b0);
        wait_done(3000, "wrap");
        check_end("wrap", 0, 1);

        // every word corrupt: error count saturates
        corrupt_all = 1;
        push_run(2'd3, 32'h5A5A_5A5A, AW'(32'h800), 1, 1);
        start_run(2'd3, 32'h5A5A_5A5A, AW'(32'h800), CW'(1), 1'b0);
        wait_done(2000, "sat");
        corrupt_all = 0;
        check_end("sat", 15, 1);
        chk("sat_first_err_addr", 64'(first_err_addr), 64'h800);

        // loop mode, stop in the middle of the third pass read-back
        push_run(2'd0, 32'h100, AW'(32'h2000), 1, 3);
        start_run(2'd0, 32'h100, AW'(32'h2000), CW'(1), 1'b1);
        n = 0;
        while (pass_count !== CW'(2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("loop_pass2", 64'(pass_count), 64'd2);
        p0 = rd_pops;
        n = 0;
        while (rd_pops < p0 + 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("loop_in_rd_data", 64'(rd_en), 64'd1);
        stop = 1'b1;
        @(negedge clk);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_aborted", 64'(aborted), 64'd1);
        chk("stop_done", 64'(done), 64'd0);
        chk("stop_pass_count", 64'(pass_count), 64'd2);
        chk("stop_error_count", 64'(error_count), 64'd0);
        stop = 1'b0;
        loop_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stop_idle_strobes", 64'({cmd_en, wr_en, rd_en}), 64'd0);
            @(negedge clk);
        end
        chk("stop_wr_left", 64'(exp_wr.size()), 64'd0);
        chk("stop_cmd_left", 64'(exp_cmd.size()), 64'd0);
        rq.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
